noc_flit_injector: RTL and testbench
====================================

Name: noc_flit_injector

Overview:
- Per-port initiator that feeds one router input of the NoC crossbar arbiter.
- Buffers incoming flits in a local FIFO.
- Raises a request toward the arbiter and drives the flit_id and length sideband the arbiter timer consumes.
- Streams the packet while granted, and re-requests and resumes if the grant is withdrawn mid-packet (arbiter timeout).

Parameters:
- DATA_W, 32, flit payload width; must be >= 12.
- DEPTH, 8, FIFO depth in flits; power of two, >= 2.
- AW, 3, FIFO pointer width, log2(DEPTH).
- WAIT_LIMIT, 1023, REQ cycles without grant before starve_err (only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  upstream flit valid
- in_ready  out  1  upstream may write; equals !full
- in_data  in  DATA_W  upstream flit; on a header flit, bits [11:0] = packet length in flits
- req  out  1  request to arbiter
- grant  in  1  this port's grant from arbiter, level, same cycle
- flit_valid  out  1  flit transferred this cycle
- flit_data  out  DATA_W  FIFO head flit
- flit_id  out  3  000 idle, 001 header, 010 body, 100 tail
- length  out  12  latched packet length; stable for the whole packet
- busy  out  1  state != IDLE
- starve_err  out  1  one-cycle pulse on starvation (optional feature)

Behaviour:
- Reset values:
  - req=0, flit_valid=0, flit_id=000, length=0, busy=0, starve_err=0.
  - FIFO pointers and count = 0; state = IDLE; sent counter = 0.
  - Reset mid-packet discards all buffered flits; no tail is emitted.
- FIFO:
  - Write on in_valid && in_ready.
  - Pop on flit_valid.
  - Simultaneous write and pop when full is not possible, because in_ready=0.
  - Simultaneous write and pop when non-full keeps count unchanged.
  - Pointers wrap modulo DEPTH.
- Packet framing:
  - The first flit written after reset, or after a tail pop, is a header.
  - Length L is taken from head in_data[11:0] when leaving IDLE.
  - L of 0 or 1 is clamped to 2 (header + tail).
  - L > 4095 is not possible.
- FSM IDLE:
  - req=0.
  - If the FIFO is non-empty: latch length, sent=0, go to REQ next cycle.
- FSM REQ:
  - req=1.
  - grant sampled 1 at the edge -> SEND.
- FSM SEND:
  - req=1.
  - flit_valid = grant && !empty, combinational from the FIFO head.
  - flit_id = 001 if sent==0; 100 if sent==L-1; else 010.
  - flit_id = 000 when flit_valid=0.
  - sent increments on each flit_valid.
  - Pop of the tail (sent==L-1) -> GAP.
  - grant=0 while in SEND -> REQ; sent is kept, so the resumed flit is body or tail, never a second header.
  - FIFO empty with grant=1: stall in SEND, req held, flit_valid=0.
- FSM GAP:
  - req=0 for exactly one cycle, so the arbiter sees the request drop and releases the port.
  - Then -> IDLE.
- Latency:
  - Header available at IDLE -> req high 1 cycle later.
  - Grant -> first flit 1 cycle after the grant edge.
  - Back-to-back packets are separated by at least 2 req-low cycles (GAP + IDLE).
- length output holds the latched value from IDLE exit through GAP; the header cycle carries flit_id=001 with the valid length, as the arbiter timer requires.

Optional Feature:
- Macro: NOC_INJ_STARVE_DETECT_EN.
- Defined:
  - A 16-bit wait counter increments each cycle in REQ with grant=0.
  - It clears on entering SEND, in IDLE, and on rst.
  - When it reaches WAIT_LIMIT, starve_err pulses high for one cycle and the counter clears.
  - Request behaviour is unchanged.
- Undefined: starve_err is tied 0 and no counter is synthesized.

Test Plan:
- Reset, then write a 4-flit packet (header data[11:0]=4), grant held 1 -> req rises 1 cycle after the header write; flit_id sequence 001,010,010,100 on 4 consecutive cycles; req=0 for 1 cycle afterwards; FIFO empty.
- Header with data[11:0]=1 -> two flits sent, ids 001 then 100.
- 6-flit packet, grant dropped after 2 flits for 3 cycles -> req stays 1 throughout; on re-grant the ids continue 010,010,010,100; no duplicate header; total 6 pops.
- Write 8 flits with grant=0 -> in_ready=0 after the 8th write; a 9th in_valid is not accepted; granting drains the flits in order and in_ready reasserts after the first pop.
- Assert rst mid-packet after 2 of 5 flits -> next cycle req=0, flit_id=000, busy=0, FIFO empty; a new 2-flit packet afterwards starts with a header.
- With NOC_INJ_STARVE_DETECT_EN and WAIT_LIMIT=10, hold grant=0 -> starve_err pulses on REQ cycle 10 and again on cycle 20; without the macro, starve_err stays 0.

Source files
------------

// File: rtl/noc_flit_injector.sv
// Per-port NoC initiator: buffers flits, requests the crossbar arbiter and streams packets while granted.
// Optional starvation detector enabled by defining NOC_INJ_STARVE_DETECT_EN.
module noc_flit_injector #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 8,
  parameter int AW         = 3,
  parameter int WAIT_LIMIT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              req,
  input  logic              grant,
  output logic              flit_valid,
  output logic [DATA_W-1:0] flit_data,
  output logic [2:0]        flit_id,
  output logic [11:0]       length,
  output logic              busy,
  output logic              starve_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam logic [2:0] ID_NONE = 3'b000;
  localparam logic [2:0] ID_HEAD = 3'b001;
  localparam logic [2:0] ID_BODY = 3'b010;
  localparam logic [2:0] ID_TAIL = 3'b100;

  if (DATA_W < 12 || DEPTH < 2 || DEPTH != (1 << AW) || WAIT_LIMIT < 1 || WAIT_LIMIT > 65535)
  begin : g_bad_params
    $error("noc_flit_injector: illegal parameter combination");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              full;
  logic              empty;
  logic              wr_en;
  logic              pop;

  logic [1:0]        state;
  logic [11:0]       sent;
  logic [11:0]       len_q;
  logic [11:0]       head_raw;
  logic [11:0]       head_len;
  logic              is_tail;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign wr_en    = in_valid && in_ready;
  assign pop      = flit_valid;

  // NOTE: the storage array has no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Header length field; 0 or 1 still means header + tail.
  assign head_raw = mem[rd_ptr][11:0];
  assign head_len = (head_raw < 12'd2) ? 12'd2 : head_raw;
  assign is_tail  = (sent == len_q - 12'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      len_q <= '0;
      sent  <= '0;
    end else begin
      case (state)
        S_IDLE: if (!empty) begin
          len_q <= head_len;
          sent  <= '0;
          state <= S_REQ;
        end
        S_REQ: if (grant) state <= S_SEND;
        S_SEND: begin
          if (pop) begin
            sent <= sent + 12'd1;
            if (is_tail) state <= S_GAP;
          end else if (!grant) begin
            state <= S_REQ;
          end
        end
        S_GAP:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req        = (state == S_REQ) || (state == S_SEND);
  assign busy       = (state != S_IDLE);
  assign flit_valid = (state == S_SEND) && grant && !empty;
  assign flit_data  = mem[rd_ptr];
  assign length     = len_q;

  // NOTE: defaulting the output first in always_comb prevents an inferred latch.
  always_comb begin
    flit_id = ID_NONE;
    if (flit_valid) begin
      if (sent == '0)   flit_id = ID_HEAD;
      else if (is_tail) flit_id = ID_TAIL;
      else              flit_id = ID_BODY;
    end
  end

`ifdef NOC_INJ_STARVE_DETECT_EN
  logic [15:0] wait_cnt;
  logic        starve_hit;

  assign starve_hit = (state == S_REQ) && !grant && (wait_cnt == 16'(WAIT_LIMIT - 1));
  assign starve_err = starve_hit;

  // Counts ungranted REQ cycles; cleared when the grant arrives or the port goes idle.
  always_ff @(posedge clk) begin
    if (rst || state == S_IDLE) begin
      wait_cnt <= '0;
    end else if (state == S_REQ) begin
      if (grant || starve_hit) wait_cnt <= '0;
      else                     wait_cnt <= wait_cnt + 16'd1;
    end
  end
`else
  assign starve_err = 1'b0;
`endif

endmodule

// File: tb/tb_noc_flit_injector.sv
// Directed bench for noc_flit_injector: framing, grant withdrawal, FIFO full, reset and starvation.
module tb_noc_flit_injector;

  localparam int WL = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        req;
  logic        grant;
  logic        flit_valid;
  logic [31:0] flit_data;
  logic [2:0]  flit_id;
  logic [11:0] length;
  logic        busy;
  logic        starve_err;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  int pops_base;

  noc_flit_injector #(
    .DATA_W(32), .DEPTH(8), .AW(3), .WAIT_LIMIT(WL)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .req(req), .grant(grant),
    .flit_valid(flit_valid), .flit_data(flit_data), .flit_id(flit_id),
    .length(length), .busy(busy), .starve_err(starve_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && flit_valid) pops++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic g);
    in_valid = v;
    in_data  = d;
    grant    = g;
    #1;
  endtask

  task automatic chk_flit(input string tag, input logic [2:0] id, input logic [31:0] d);
    check({tag, ".valid"}, 32'(flit_valid), 32'd1);
    check({tag, ".id"},    32'(flit_id),    32'(id));
    check({tag, ".data"},  flit_data,       d);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    adv();
    adv();
    check("rst.req",    32'(req),        32'd0);
    check("rst.fv",     32'(flit_valid), 32'd0);
    check("rst.id",     32'(flit_id),    32'd0);
    check("rst.len",    32'(length),     32'd0);
    check("rst.busy",   32'(busy),       32'd0);
    check("rst.starve", 32'(starve_err), 32'd0);
    check("rst.ready",  32'(in_ready),   32'd1);
    rst = 1'b0;
    adv();

    // 4-flit packet, grant held high
    pops_base = pops;
    drive(1'b1, 32'hA000_0004, 1'b1); check("p4.a.req", 32'(req), 32'd0); adv();
    drive(1'b1, 32'hA111_1111, 1'b1); check("p4.b.req", 32'(req), 32'd0); adv();
    drive(1'b1, 32'hA222_2222, 1'b1);
    check("p4.c.req", 32'(req), 32'd1);
    check("p4.c.busy", 32'(busy), 32'd1);
    check("p4.c.len", 32'(length), 32'd4);
    check("p4.c.fv", 32'(flit_valid), 32'd0);
    adv();
    drive(1'b1, 32'hA333_3333, 1'b1); chk_flit("p4.f0", 3'b001, 32'hA000_0004);
    check("p4.f0.len", 32'(length), 32'd4); adv();
    drive(1'b0, 32'h0, 1'b1); chk_flit("p4.f1", 3'b010, 32'hA111_1111); adv();
    drive(1'b0, 32'h0, 1'b1); chk_flit("p4.f2", 3'b010, 32'hA222_2222); adv();
    drive(1'b0, 32'h0, 1'b1); chk_flit("p4.f3", 3'b100, 32'hA333_3333);
    check("p4.f3.len", 32'(length), 32'd4); adv();
    drive(1'b0, 32'h0, 1'b1);
    check("p4.gap.req", 32'(req), 32'd0);
    check("p4.gap.fv", 32'(flit_valid), 32'd0);
    check("p4.gap.busy", 32'(busy), 32'd1);
    check("p4.gap.len", 32'(length), 32'd4);
    adv();
    drive(1'b0, 32'h0, 1'b1);
    check("p4.idle.busy", 32'(busy), 32'd0);
    check("p4.idle.req", 32'(req), 32'd0);
    adv();
    check("p4.empty.busy", 32'(busy), 32'd0);
    check("p4.pops", 32'(pops - pops_base), 32'd4);

    // header length 1 is clamped to 2
    drive(1'b1, 32'hC000_0001, 1'b1); adv();
    drive(1'b1, 32'hC0DE_0777, 1'b1); adv();
    drive(1'b0, 32'h0, 1'b1);
    check("l1.req", 32'(req), 32'd1);
    check("l1.len", 32'(length), 32'd2);
    adv();
    drive(1'b0, 32'h0, 1'b1); chk_flit("l1.f0", 3'b001, 32'hC000_0001); adv();
    drive(1'b0, 32'h0, 1'b1); chk_flit("l1.f1", 3'b100, 32'hC0DE_0777); adv();
    drive(1'b0, 32'h0, 1'b1); check("l1.gap.req", 32'(req), 32'd0); adv();
    adv();

    // 6-flit packet with grant withdrawn for 3 cycles after 2 flits
    pops_base = pops;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, (i == 0) ? 32'hD000_0006 : 32'hD000_0100 + 32'(i), 1'b0);
      adv();
    end
    drive(1'b0, 32'h0, 1'b1);
    check("p6.req0", 32'(req), 32'd1);
    check("p6.fv0", 32'(flit_valid), 32'd0);
    adv();
    drive(1'b0, 32'h0, 1'b1); chk_flit("p6.f0", 3'b001, 32'hD000_0006); adv();
    drive(1'b0, 32'h0, 1'b1); chk_flit("p6.f1", 3'b010, 32'hD000_0101); adv();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b0);
      check($sformatf("p6.drop%0d.req", i), 32'(req), 32'd1);
      check($sformatf("p6.drop%0d.id", i), 32'(flit_id), 32'd0);
      adv();
    end
    drive(1'b0, 32'h0, 1'b1);
    check("p6.regrant.req", 32'(req), 32'd1);
    check("p6.regrant.fv", 32'(flit_valid), 32'd0);
    adv();
    for (int i = 2; i < 6; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      chk_flit($sformatf("p6.f%0d", i), (i == 5) ? 3'b100 : 3'b010, 32'hD000_0100 + 32'(i));
      adv();
    end
    drive(1'b0, 32'h0, 1'b1); check("p6.gap.req", 32'(req), 32'd0); adv();
    adv();
    check("p6.pops", 32'(pops - pops_base), 32'd6);

    // fill FIFO with grant low, then drain
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i == 0) ? 32'hE000_0008 : 32'hE000_0200 + 32'(i), 1'b0);
      check($sformatf("full.w%0d.ready", i), 32'(in_ready), 32'd1);
      adv();
    end
    drive(1'b1, 32'hDEAD_0009, 1'b0);
    check("full.ready", 32'(in_ready), 32'd0);
    adv();
    drive(1'b0, 32'h0, 1'b1);
    check("full.ready2", 32'(in_ready), 32'd0);
    check("full.req", 32'(req), 32'd1);
    adv();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      chk_flit($sformatf("full.f%0d", i),
               (i == 0) ? 3'b001 : ((i == 7) ? 3'b100 : 3'b010),
               (i == 0) ? 32'hE000_0008 : 32'hE000_0200 + 32'(i));
      check($sformatf("full.f%0d.ready", i), 32'(in_ready), (i == 0) ? 32'd0 : 32'd1);
      adv();
    end
    drive(1'b0, 32'h0, 1'b1); check("full.gap.req", 32'(req), 32'd0); adv();
    adv();
    adv();
    check("full.no9th.busy", 32'(busy), 32'd0);

    // reset in the middle of a 5-flit packet
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, (i == 0) ? 32'h7000_0005 : 32'h7000_0300 + 32'(i), 1'b0);
      adv();
    end
    drive(1'b0, 32'h0, 1'b1); adv();
    drive(1'b0, 32'h0, 1'b1); chk_flit("mr.f0", 3'b001, 32'h7000_0005); adv();
    drive(1'b0, 32'h0, 1'b1); chk_flit("mr.f1", 3'b010, 32'h7000_0301); adv();
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b1);
    adv();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    check("mr.req", 32'(req), 32'd0);
    check("mr.id", 32'(flit_id), 32'd0);
    check("mr.busy", 32'(busy), 32'd0);
    check("mr.len", 32'(length), 32'd0);
    check("mr.ready", 32'(in_ready), 32'd1);
    adv();
    check("mr.empty.busy", 32'(busy), 32'd0);
    drive(1'b1, 32'h5000_0002, 1'b1); adv();
    drive(1'b1, 32'h5000_0444, 1'b1); adv();
    drive(1'b0, 32'h0, 1'b1); check("mr.new.len", 32'(length), 32'd2); adv();
    drive(1'b0, 32'h0, 1'b1); chk_flit("mr.new.f0", 3'b001, 32'h5000_0002); adv();
    drive(1'b0, 32'h0, 1'b1); chk_flit("mr.new.f1", 3'b100, 32'h5000_0444); adv();
    drive(1'b0, 32'h0, 1'b1); check("mr.new.gap", 32'(req), 32'd0); adv();
    adv();

    // long ungranted request: starve_err only with the detector built in
    drive(1'b1, 32'h6000_0002, 1'b0); adv();
    drive(1'b1, 32'h6000_0555, 1'b0); adv();
    for (int k = 1; k <= 25; k++) begin
      drive(1'b0, 32'h0, 1'b0);
      check($sformatf("st.c%0d.req", k), 32'(req), 32'd1);
`ifdef NOC_INJ_STARVE_DETECT_EN
      check($sformatf("st.c%0d.err", k), 32'(starve_err), (k % WL == 0) ? 32'd1 : 32'd0);
`else
      check($sformatf("st.c%0d.err", k), 32'(starve_err), 32'd0);
`endif
      adv();
    end
    drive(1'b0, 32'h0, 1'b1); check("st.grant.err", 32'(starve_err), 32'd0); adv();
    drive(1'b0, 32'h0, 1'b1); chk_flit("st.f0", 3'b001, 32'h6000_0002); adv();
    drive(1'b0, 32'h0, 1'b1); chk_flit("st.f1", 3'b100, 32'h6000_0555); adv();
    drive(1'b0, 32'h0, 1'b0); check("st.gap.req", 32'(req), 32'd0); adv();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
